// File: rtl/rr_mux_pkg.sv
// Shared defaults and the channel-index width helper for the round-robin mux.
package rr_mux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant from a rotating pointer; grant is combinational, the pointer
// advances past the served channel only when the caller asks it to.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = ch_w(DEF_NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           upd,
  input  logic [CW-1:0]  upd_idx,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  grant_idx
);

  logic [CW-1:0] ptr;
  logic          found;
  int            idx;

  // First requester at or above ptr, wrapping from NCH-1 back to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NCH; off++) begin
      idx = (int'(ptr) + off) % NCH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = CW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (upd_idx == CW'(NCH - 1)) ? '0 : upd_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux.sv
// NCH-to-1 round-robin mux into a single output register: 1-cycle latency, full rate,
// in_ready only while the slot is free. RR_MUX_PKT_LOCK_EN holds the grant for a whole packet.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [ch_w(NCH)-1:0]   out_ch
);

  localparam int CW = ch_w(NCH);

  logic [NCH-1:0]   req;
  logic [NCH-1:0]   grant;
  logic [CW-1:0]    grant_idx;
  logic             slot_free;
  logic             hs;
  logic             ptr_upd;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (slot_free && !rst) ? grant : '0;
  // in_ready is a subset of req, which is a subset of in_valid.
  assign hs        = |in_ready;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
  end

`ifdef RR_MUX_PKT_LOCK_EN
  logic          locked;
  logic [CW-1:0] lock_ch;

  always_comb begin
    req = '0;
    for (int i = 0; i < NCH; i++) begin
      req[i] = in_valid[i] && (!locked || lock_ch == CW'(i));
    end
  end

  assign ptr_upd = hs && sel_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (hs) begin
      locked  <= !sel_last;
      lock_ch <= grant_idx;
    end
  end
`else
  assign req     = in_valid;
  assign ptr_upd = hs;
`endif

  rr_arbiter #(
    .NCH(NCH),
    .CW (CW)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .upd      (ptr_upd),
    .upd_idx  (grant_idx),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (hs) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits; SHALL be >= 1.
REQ-002 Parameter NCH, default 4, number of input channels; SHALL be >= 2.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge; reset is synchronous and active-high.
REQ-004 Port rst, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid, input, NCH: per-channel valid.
REQ-006 Port in_ready, output, NCH: per-channel ready; one-hot or zero.
REQ-007 Port in_data, input, NCH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port in_last, input, NCH: per-channel end-of-packet marker.
REQ-009 Port out_valid, output, 1: output register holds a beat.
REQ-010 Port out_ready, input, 1: downstream accepts the beat.
REQ-011 Port out_data, output, WIDTH: registered selected data.
REQ-012 Port out_last, output, 1: registered in_last of the selected beat.
REQ-013 Port out_ch, output, clog2(NCH): index of the source channel of the held beat.

Function
REQ-014 The transfer rule SHALL be: a beat moves on a handshake when valid and ready are both high in the same cycle.
REQ-015 The output slot SHALL count as free when out_valid is 0 or out_ready is 1.
REQ-016 When the slot is free, the arbiter SHALL grant exactly one requesting channel; in_ready SHALL equal that grant, or zero when nothing is granted.
REQ-017 The arbiter SHALL use round-robin order, searching from pointer ptr upward with wrap from NCH-1 to 0.
REQ-018 After a handshake on channel g, ptr SHALL become (g+1) mod NCH; otherwise ptr SHALL hold.
REQ-019 Latency SHALL be 1 cycle: an input handshake in cycle n gives out_valid=1 with that data, last and ch in cycle n+1.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_last and out_ch SHALL stay stable and in_ready SHALL be all zero.
REQ-021 If out_ready=1 and no input handshake occurs, out_valid SHALL drop to 0 in the next cycle.
REQ-022 Simultaneous output drain and input handshake SHALL sustain full throughput of 1 beat per cycle with no bubble.
REQ-023 When in_valid is all zero, in_ready SHALL be zero and ptr SHALL hold.
REQ-024 in_ready SHALL be a combinational function of in_valid, out_valid, out_ready and state; there SHALL be no combinational path from in_data to any output.

Reset
REQ-025 With rst=1 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_last=0, out_ch=0, ptr=0 and lock cleared.
REQ-026 While rst=1, in_ready SHALL be all zero.
REQ-027 Reset asserted mid-packet or with a beat held SHALL discard that beat; after reset, channel 0 SHALL have first priority.

Configuration
REQ-028 Macro RR_MUX_PKT_LOCK_EN defined: after a handshake with in_last=0 on channel g, the grant SHALL stay locked to g, ignoring other requests, until a handshake with in_last=1 on g; ptr SHALL update only on that final beat.
REQ-029 Macro RR_MUX_PKT_LOCK_EN undefined: arbitration SHALL occur on every beat; in_last SHALL only pass through to out_last.
REQ-030 While locked with in_valid[g]=0, no channel SHALL be granted.

Structure
REQ-031 Package rr_mux_pkg SHALL hold default WIDTH and NCH constants and a function computing the channel-index width.
REQ-032 Sub-module rr_arbiter SHALL hold the NCH-wide round-robin request/pointer/grant logic; rr_mux SHALL hold the output register, handshake and lock logic.

Verification
REQ-033 Scenario 1: NCH=4, WIDTH=8, only ch2 valid with data 0xA5, out_ready=1 -> in_ready=0100 at once; next cycle out_valid=1, out_data=0xA5, out_ch=2.
REQ-034 Scenario 2: all 4 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 Scenario 3: beat held, out_ready=0 for 3 cycles -> out_data stable and in_ready=0000 throughout; out_ready=1 -> next beat follows with no bubble.
REQ-036 Scenario 4: rst=1 for one cycle while out_valid=1 and ptr=3 -> out_valid=0; next arbitration with all channels valid grants ch0.
REQ-037 Scenario 5 (RR_MUX_PKT_LOCK_EN): ch1 sends a 3-beat packet with last on beat 3 while ch0 and ch2 are valid -> out_ch=1,1,1 then 2.
REQ-038 Scenario 6 (RR_MUX_PKT_LOCK_EN undefined): same stimulus as Scenario 5 -> out_ch=1,2,0,1.
